// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: state codes, frame bundle and bit-period math.
// Used by both the receiver and the transmitter so their timing matches.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    s_idle   = 3'b000,
    s_start  = 3'b001,
    s_data   = 3'b010,
    s_parity = 3'b011,
    s_stop   = 3'b100
  } uart_state_t;

  typedef struct packed {
    logic [7:0] data;
    logic       parity_err;
    logic       frame_err;
  } rx_frame_t;

  function automatic int clk_cycle_calc(
    input int clk_mhz,
    input int baud
  );
    return (clk_mhz * 1000000) / baud;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the serial line plus a delay flop
// that flags a synchronised falling edge (start-bit candidate).
module uart_rx_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_rx,
  output logic rx_s,
  output logic fall_edge
);

  logic meta;
  logic sync;
  logic prev;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      meta <= 1'b1;
      sync <= 1'b1;
      prev <= 1'b1;
    end else begin
      meta <= i_rx;
      sync <= meta;
      prev <= sync;
    end
  end

  assign rx_s      = sync;
  assign fall_edge = prev & ~sync;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8 data bits LSB first, even parity, one stop bit,
// mid-bit sampling, byte plus error flags on a valid/ready handshake.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int clk_frequency = 27,
  parameter int baud_rate     = 115200
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun
);

  localparam int clk_cycle  = clk_cycle_calc(clk_frequency, baud_rate);
  localparam int half_cycle = clk_cycle / 2;
  localparam int cnt_w      = $clog2(clk_cycle);

  localparam logic [cnt_w-1:0] cnt_full = cnt_w'(clk_cycle - 1);
  localparam logic [cnt_w-1:0] cnt_half = cnt_w'(half_cycle - 1);
  localparam logic [cnt_w-1:0] cnt_one  = cnt_w'(1);

  logic             rx_s;
  logic             fall_edge;
  uart_state_t      state;
  logic [cnt_w-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             par_bit;
  logic             tick_full;
  logic             frame_done;
  rx_frame_t        frame;
  logic             do_load;
  logic             do_drop;
  logic             do_accept;

  uart_rx_sync u_sync (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_rx      (i_rx),
    .rx_s      (rx_s),
    .fall_edge (fall_edge)
  );

  assign tick_full  = (cnt == cnt_full);
  assign frame_done = (state == s_stop) && tick_full;

  // Stop bit is taken straight from the line in the completing cycle.
  always_comb begin
    frame            = '0;
    frame.data       = shift;
    frame.parity_err = par_bit ^ (^shift);
    frame.frame_err  = ~rx_s;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= s_idle;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      par_bit <= 1'b0;
    end else begin
      unique case (state)
        s_idle: begin
          cnt     <= '0;
          bit_idx <= '0;
          if (fall_edge) state <= s_start;
        end
        s_start: begin
          if (cnt == cnt_half) begin
            cnt   <= '0;
            state <= rx_s ? s_idle : s_data;
          end else begin
            cnt <= cnt + cnt_one;
          end
        end
        s_data: begin
          if (tick_full) begin
            cnt            <= '0;
            shift[bit_idx] <= rx_s;
            bit_idx        <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= s_parity;
          end else begin
            cnt <= cnt + cnt_one;
          end
        end
        s_parity: begin
          if (tick_full) begin
            cnt     <= '0;
            par_bit <= rx_s;
            state   <= s_stop;
          end else begin
            cnt <= cnt + cnt_one;
          end
        end
        s_stop: begin
          if (tick_full) begin
            cnt   <= '0;
            state <= s_idle;
          end else begin
            cnt <= cnt + cnt_one;
          end
        end
        default: state <= s_idle;
      endcase
    end
  end

  assign do_load   = frame_done & (~rx_valid | rx_ready);
  assign do_drop   = frame_done & rx_valid & ~rx_ready;
  assign do_accept = ~frame_done & rx_valid & rx_ready;

  // The receiver never stalls; an unaccepted byte wins over a new one.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      unique case (1'b1)
        do_load: begin
          rx_data    <= frame.data;
          parity_err <= frame.parity_err;
          frame_err  <= frame.frame_err;
          rx_valid   <= 1'b1;
        end
        do_drop:   overrun  <= 1'b1;
        do_accept: rx_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
